// File: rtl/arm_pkg.sv
// Shared constants for the ARM execution units: register indexing
// and the iterative multiplier's state encoding.
package arm_pkg;

    localparam int REG_IDX_W = 4;

    localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

endpackage

// File: rtl/mul_unit.sv
// Iterative MUL/MLA unit: shift-add over Rs with early exit once the
// remaining multiplier bits are zero, then a one-cycle write-back.
module mul_unit
    import arm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 accumulate,
    input  logic                 set_flags,
    input  logic [REG_IDX_W-1:0] Rd,
    input  logic [DATA_W-1:0]    Rm_data,
    input  logic [DATA_W-1:0]    Rs_data,
    input  logic [DATA_W-1:0]    Rn_data,
    output logic                 busy,
    output logic                 done,
    output logic                 latch_reg,
    output logic [REG_IDX_W-1:0] Rd_out,
    output logic [DATA_W-1:0]    data_out,
    output logic                 flags_we,
    output logic                 flag_n,
    output logic                 flag_z
);

    logic [1:0]           state;
    logic [DATA_W-1:0]    acc;
    logic [DATA_W-1:0]    mcand;
    logic [DATA_W-1:0]    mplier;
    logic [REG_IDX_W-1:0] rd_q;
    logic                 s_q;

    logic [DATA_W-1:0]    acc_nxt;
    logic                 last;

    assign acc_nxt = mplier[0] ? acc + mcand : acc;
    assign last    = (mplier[DATA_W-1:1] == '0);
    assign busy    = (state != IDLE);

    // WRITE-cycle outputs are loaded on the final CALC edge so that
    // everything the register bank sees comes straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rd_q      <= '0;
            s_q       <= 1'b0;
            done      <= 1'b0;
            latch_reg <= 1'b0;
            Rd_out    <= '0;
            data_out  <= '0;
            flags_we  <= 1'b0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
        end else begin
            done      <= 1'b0;
            latch_reg <= 1'b0;
            flags_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= accumulate ? Rn_data : '0;
                        mcand  <= Rm_data;
                        mplier <= Rs_data;
                        rd_q   <= Rd;
                        s_q    <= set_flags;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (last) begin
                        state    <= WRITE;
                        done     <= 1'b1;
                        data_out <= acc_nxt;
                        // Writes to the PC are suppressed.
                        if (rd_q != PC_IDX) begin
                            latch_reg <= 1'b1;
                            Rd_out    <= rd_q;
                        end
                        if (s_q) begin
                            flags_we <= 1'b1;
                            flag_n   <= acc_nxt[DATA_W-1];
                            flag_z   <= (acc_nxt == '0);
                        end
                    end
                end
                WRITE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: scoreboard of expected write-backs
// plus per-scenario latency and control checks.
module tb_mul_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        accumulate;
    logic        set_flags;
    logic [3:0]  Rd;
    logic [31:0] Rm_data;
    logic [31:0] Rs_data;
    logic [31:0] Rn_data;
    logic        busy;
    logic        done;
    logic        latch_reg;
    logic [3:0]  Rd_out;
    logic [31:0] data_out;
    logic        flags_we;
    logic        flag_n;
    logic        flag_z;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        logic        fwe;
        logic        n;
        logic        z;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    mul_unit #(.DATA_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .accumulate(accumulate),
        .set_flags(set_flags),
        .Rd(Rd),
        .Rm_data(Rm_data),
        .Rs_data(Rs_data),
        .Rn_data(Rn_data),
        .busy(busy),
        .done(done),
        .latch_reg(latch_reg),
        .Rd_out(Rd_out),
        .data_out(data_out),
        .flags_we(flags_we),
        .flag_n(flag_n),
        .flag_z(flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int kfun(input logic [31:0] rs);
        int k;
        k = 1;
        for (int i = 0; i < 32; i++)
            if (rs[i]) k = i + 1;
        return k;
    endfunction

    // Scoreboard: every done must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done: done=1 with no request outstanding, data_out=%h", data_out);
                end else begin
                    e = sb.pop_front();
                    if (data_out !== e.data) begin
                        errors++;
                        $display("FAIL data_out: got %h want %h", data_out, e.data);
                    end
                    checks++;
                    if (latch_reg !== (e.rd != 4'd15)) begin
                        errors++;
                        $display("FAIL latch_reg: got %b want %b (rd=%0d)", latch_reg, e.rd != 4'd15, e.rd);
                    end
                    if (e.rd != 4'd15) begin
                        checks++;
                        if (Rd_out !== e.rd) begin
                            errors++;
                            $display("FAIL Rd_out: got %0d want %0d", Rd_out, e.rd);
                        end
                    end
                    checks++;
                    if (flags_we !== e.fwe) begin
                        errors++;
                        $display("FAIL flags_we: got %b want %b", flags_we, e.fwe);
                    end
                    if (e.fwe) begin
                        checks++;
                        if ({flag_n, flag_z} !== {e.n, e.z}) begin
                            errors++;
                            $display("FAIL flags_nz: got %b%b want %b%b", flag_n, flag_z, e.n, e.z);
                        end
                    end
                end
            end
            if ((latch_reg && !done) || (flags_we && !done)) begin
                errors++;
                $display("FAIL strobe_without_done: latch_reg=%b flags_we=%b", latch_reg, flags_we);
            end
        end
    end

    // Drives one start cycle; returns at the negedge of the first CALC cycle.
    task automatic issue(input logic acc, input logic s, input logic [3:0] rd,
                         input logic [31:0] rm, input logic [31:0] rs,
                         input logic [31:0] rn, input bit push);
        exp_t x;
        logic [31:0] r;
        r = rm * rs + (acc ? rn : 32'd0);
        x.rd   = rd;
        x.data = r;
        x.fwe  = s;
        x.n    = r[31];
        x.z    = (r == 32'd0);
        if (push) sb.push_back(x);
        accumulate = acc;
        set_flags  = s;
        Rd         = rd;
        Rm_data    = rm;
        Rs_data    = rs;
        Rn_data    = rn;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        Rm_data    = $urandom;
        Rs_data    = $urandom;
        Rn_data    = $urandom;
        Rd         = 4'($urandom);
    endtask

    // n counts the current cycle as 1; -1 if done never arrives.
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        accumulate = 1'b0;
        set_flags = 1'b0;
        Rd = 4'd0;
        Rm_data = '0;
        Rs_data = '0;
        Rn_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, latch_reg, flags_we, flag_n, flag_z, Rd_out, data_out} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b latch=%b fwe=%b n=%b z=%b rd=%0d data=%h want all 0",
                     busy, done, latch_reg, flags_we, flag_n, flag_z, Rd_out, data_out);
        end
    endtask

    task automatic test_mul();
        int n;
        issue(1'b0, 1'b0, 4'd3, 32'd7, 32'd6, 32'd0, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mul_busy: got %b want 1", busy);
        end
        wait_done(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL mul_latency: got %0d want 4", n);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy_fall: got %b want 0", busy);
        end
    endtask

    task automatic test_mla();
        int n;
        issue(1'b1, 1'b0, 4'd4, 32'd3, 32'd5, 32'd100, 1'b1);
        wait_done(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL mla_latency: got %0d want 4", n);
        end
        @(negedge clk);
    endtask

    task automatic test_flags_zero();
        int n;
        issue(1'b0, 1'b1, 4'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
        wait_done(n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL zero_latency: got %0d want 2", n);
        end
        @(negedge clk);
    endtask

    task automatic test_flags_neg_busy_start();
        int n;
        issue(1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
        repeat (5) @(negedge clk);
        accumulate = 1'b0;
        set_flags  = 1'b1;
        Rd         = 4'd7;
        Rm_data    = 32'd1;
        Rs_data    = 32'd1;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_done(n);
        checks++;
        if (n < 0 || n + 6 != 33) begin
            errors++;
            $display("FAIL neg_latency: got %0d want 33", n < 0 ? n : n + 6);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL ignored_start_queued: busy=%b cycle %0d after done", busy, i + 1);
            end
        end
    endtask

    task automatic test_pc();
        int n;
        issue(1'b0, 1'b0, 4'd15, 32'd2, 32'd2, 32'd0, 1'b1);
        wait_done(n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL pc_latency: got %0d want 3", n);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int n;
        issue(1'b0, 1'b1, 4'd5, 32'd1, 32'h0000_FFFF, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        Rs_data = 32'd3;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, done, latch_reg, flags_we, flag_n, flag_z, Rd_out, data_out} !== 42'd0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b done=%b latch=%b fwe=%b n=%b z=%b rd=%0d data=%h want all 0",
                     busy, done, latch_reg, flags_we, flag_n, flag_z, Rd_out, data_out);
        end
        repeat (20) @(negedge clk);
        issue(1'b1, 1'b1, 4'd9, 32'd1, 32'h0000_FFFF, 32'h1234_0000, 1'b1);
        wait_done(n);
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL after_abort_latency: got %0d want 17", n);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] rs;
        for (int i = 0; i < 8; i++) begin
            rs = $urandom >> $urandom_range(0, 31);
            issue(1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)),
                  $urandom, rs, $urandom, 1'b1);
            wait_done(n);
            checks++;
            if (n != kfun(rs) + 1) begin
                errors++;
                $display("FAIL b2b_latency: op %0d got %0d want %0d", i, n, kfun(rs) + 1);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mla();
        test_flags_zero();
        test_flags_neg_busy_start();
        test_pc();
        test_abort();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never produced, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
